uwasic_onboarding_evelynn_lu: RTL and testbench
===============================================

# uwasic_onboarding_evelynn_lu

Top-level user block for the onboarding tile (`tt_um_uwasic_onboarding_evelynn_lu`). It contains a write-only SPI peripheral that loads five 8-bit control registers. It also contains an 8-bit PWM generator. Together these drive 16 outputs (`uo_out`, `uio_out`), each either static or PWM-modulated. The block is intended for a 10 MHz system clock.

## Interface
- Parameters: none.
- `clk` — input, 1 bit. System clock, 10 MHz nominal.
- `rst_n` — input, 1 bit. Asynchronous reset, active-high: asserted when 1. The codebase port name is kept.
- `ena` — input, 1 bit. Design-selected flag; ignored.
- `ui_in` — input, 8 bits.
  - [0] SCLK, [1] COPI, [2] nCS.
  - [7:3] unused.
- `uio_in` — input, 8 bits. Unused.
- `uo_out` — output, 8 bits. Outputs 7:0.
- `uio_out` — output, 8 bits. Outputs 15:8.
- `uio_oe` — output, 8 bits. Constant 8'hFF.

## Operation
- SPI mode 0, MSB first, 16-bit frame:
  - bit15: R/W, 1 = write.
  - bits14:8: address.
  - bits7:0: data.
- SCLK, COPI and nCS each pass through a 2-flop synchronizer. A third flop provides edge detection.
- While nCS is low, COPI is shifted in on each synchronized SCLK rising edge. A bit counter saturates at 16.
- On the synchronized nCS rising edge, the frame commits only if all of these hold:
  - bit15 = 1;
  - address ≤ 0x04;
  - the length check passes (see Configuration).
- Otherwise the frame is dropped and the shift register and counter are cleared.
- Read frames (bit15 = 0) have no effect. There is no CIPO pin.
- Registers:
  - 0x00 `en_out[7:0]`
  - 0x01 `en_out[15:8]`
  - 0x02 `en_pwm[7:0]`
  - 0x03 `en_pwm[15:8]`
  - 0x04 `duty[7:0]`
- PWM:
  - A prescaler counts 0..12 (divide by 13).
  - An 8-bit counter increments on each prescaler wrap and wraps 255 → 0.
  - Resulting period = 13 × 256 clk = 332.8 µs, about 3.004 kHz.
- `pwm` signal:
  - duty = 0x00: constant 0.
  - duty = 0xFF: constant 1.
  - otherwise: 1 when counter < duty.
- Output rule: `out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0`.
- All outputs are registered.

## Timing
- Reset clears everything to 0 immediately:
  - all five registers;
  - shift register, bit counter, synchronizers;
  - prescaler, PWM counter;
  - `uo_out` and `uio_out` (0x00 each).
- `uio_oe` stays 0xFF during and after reset.
- Register update occurs 4 clk after the raw nCS rising edge:
  - 2 synchronizer stages, 1 edge-detect stage, 1 write stage.
- Output reflects a new register value 1 clk after the register updates.
- SCLK high and low phases must each be ≥ 4 clk periods (SCLK ≤ 1.25 MHz).
- COPI must be stable ≥ 3 clk before the SCLK rising edge.
- nCS deasserted mid-frame: the frame is dropped when the length check is enabled.
- Reset mid-frame: the partial frame is discarded. The next frame starts clean after nCS goes low.
- A duty write takes effect on the next clk. The PWM counter is not restarted, so the current period may be mixed.
- SCLK edges while nCS is high are ignored.

## Configuration
- `SPI_LEN_CHECK_EN`:
  - Defined: a frame commits only if exactly 16 SCLK rising edges occurred during nCS low. Fewer or more edges drop the frame.
  - Undefined: any frame with ≥ 16 edges commits using the first 16 bits. Frames with < 16 edges are dropped.

## Structure
- Shared package `uwasic_onb_pkg`:
  - register address constants `ADDR_EN_OUT_LO` … `ADDR_DUTY`;
  - `PWM_PRESCALE = 13`;
  - `FRAME_BITS = 16`;
  - `NUM_REGS = 5`.
- One sub-module, `spi_peripheral`:
  - contains the synchronizers, shift register, frame validation and register file;
  - exports the five registers.
- PWM generation and output muxing live in the top module.

## Test plan
- Reset → `uo_out` = 0x00, `uio_out` = 0x00, `uio_oe` = 0xFF.
- Write 0x00 ← 0xF0, then 0x01 ← 0xCC → `uo_out` = 0xF0, `uio_out` = 0xCC within 5 clk of nCS high.
- Send frames expected to be dropped:
  - read frame (bit15 = 0), addr 0x00, data 0xFF;
  - write to addr 0x30.
  - → outputs unchanged.
- `en_out[0]` = 1, `en_pwm[0]` = 1:
  - duty 0x80 → `uo_out[0]` period 3328 clk ± 1, high time 128 × 13 clk (50%);
  - duty 0x00 → constant 0;
  - duty 0xFF → constant 1.
- Pulse nCS low with only 8 SCLK edges → no register change, with or without `SPI_LEN_CHECK_EN`.
- Assert reset mid-frame after 10 bits, release, then send a full write 0x00 ← 0x55 → `uo_out` = 0x55.

Source files
------------

// File: rtl/uwasic_onb_pkg.sv
// Shared constants and frame layout for the onboarding tile.
// Holds the SPI register map, frame width and PWM prescale.
package uwasic_onb_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int PWM_PRESCALE = 13;
  localparam int FRAME_BITS   = 16;
  localparam int NUM_REGS     = 5;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } spi_frame_t;

  function automatic logic frame_targets_reg(spi_frame_t f);
    return f.wr && (f.addr <= ADDR_DUTY);
  endfunction

endpackage

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 peripheral loading five 8-bit control registers.
// Register updates 4 clk after raw nCS rises; strict 16-edge length check under SPI_LEN_CHECK_EN.
module spi_peripheral
  import uwasic_onb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_i,
  input  logic        copi_i,
  input  logic        ncs_i,
  output logic [15:0] en_out_o,
  output logic [15:0] en_pwm_o,
  output logic [7:0]  duty_o
);

  logic [2:0]            sclk_q;
  logic [1:0]            copi_q;
  logic [2:0]            ncs_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [4:0]            cnt_q;
  logic                  commit_q;
  logic [2:0]            waddr_q;
  logic [7:0]            wdata_q;
  logic [7:0]            regs_q [NUM_REGS];

  logic       sclk_rise;
  logic       ncs_rise;
  logic       ncs_low;
  logic       len_ok;
  spi_frame_t frame;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign ncs_low   = ~ncs_q[1];
  assign frame     = spi_frame_t'(shift_q);

`ifdef SPI_LEN_CHECK_EN
  // The counter saturates at 16, so a separate flag remembers edges beyond it.
  logic over_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      over_q <= 1'b0;
    end else if (ncs_rise) begin
      over_q <= 1'b0;
    end else if (ncs_low && sclk_rise && cnt_q == 5'(FRAME_BITS)) begin
      over_q <= 1'b1;
    end
  end

  assign len_ok = (cnt_q == 5'(FRAME_BITS)) && !over_q;
`else
  assign len_ok = (cnt_q == 5'(FRAME_BITS));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q   <= '0;
      copi_q   <= '0;
      ncs_q    <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], sclk_i};
      copi_q   <= {copi_q[0], copi_i};
      ncs_q    <= {ncs_q[1:0], ncs_i};
      commit_q <= 1'b0;
      if (ncs_rise) begin
        commit_q <= frame_targets_reg(frame) && len_ok;
        waddr_q  <= frame.addr[2:0];
        wdata_q  <= frame.data;
        shift_q  <= '0;
        cnt_q    <= '0;
      end else if (ncs_low && sclk_rise && cnt_q < 5'(FRAME_BITS)) begin
        // Freezing after 16 bits keeps the first 16 bits of an over-long frame.
        shift_q <= {shift_q[FRAME_BITS-2:0], copi_q[1]};
        cnt_q   <= cnt_q + 5'd1;
      end
      if (commit_q) regs_q[waddr_q] <= wdata_q;
    end
  end

  assign en_out_o = {regs_q[int'(ADDR_EN_OUT_HI)], regs_q[int'(ADDR_EN_OUT_LO)]};
  assign en_pwm_o = {regs_q[int'(ADDR_EN_PWM_HI)], regs_q[int'(ADDR_EN_PWM_LO)]};
  assign duty_o   = regs_q[int'(ADDR_DUTY)];

endmodule

// File: rtl/uwasic_onboarding_evelynn_lu.sv
// Onboarding tile top: SPI-loaded control registers driving 16 static or PWM outputs (~3 kHz PWM).
// Outputs registered, 1 clk after register update; SPI_LEN_CHECK_EN selects strict frame length.
module uwasic_onboarding_evelynn_lu
  import uwasic_onb_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  // rst_n keeps its legacy name but is active-high.
  logic rst;
  assign rst = rst_n;

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [3:0]  presc_q;
  logic [7:0]  pwm_cnt_q;
  logic [15:0] out_q;
  logic [15:0] out_d;
  logic        pwm;

  spi_peripheral u_spi (
    .clk      (clk),
    .rst      (rst),
    .sclk_i   (ui_in[0]),
    .copi_i   (ui_in[1]),
    .ncs_i    (ui_in[2]),
    .en_out_o (en_out),
    .en_pwm_o (en_pwm),
    .duty_o   (duty)
  );

  always_comb begin
    pwm = 1'b0;
    if (duty == 8'hFF) pwm = 1'b1;
    else if (duty != 8'h00) pwm = (pwm_cnt_q < duty);
    out_d = en_out & (~en_pwm | {16{pwm}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      if (presc_q == 4'(PWM_PRESCALE - 1)) begin
        presc_q   <= '0;
        pwm_cnt_q <= pwm_cnt_q + 8'd1;
      end else begin
        presc_q <= presc_q + 4'd1;
      end
      out_q <= out_d;
    end
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];
  assign uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_uwasic_onboarding_evelynn_lu.sv
// Directed bench for the onboarding tile: SPI register writes, frame drops, PWM timing, reset.
module tb_uwasic_onboarding_evelynn_lu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  uwasic_onboarding_evelynn_lu dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #50 clk = ~clk;

  // Drives nbits of word MSB first; bits past 16 are sent as 0.
  task automatic spi_send(input logic [15:0] word, input int nbits, input bit release_cs);
    @(negedge clk);
    ui_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      ui_in[1] = (i < 16) ? word[15 - i] : 1'b0;
      ui_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      ui_in[0] = 1'b1;
      repeat (5) @(negedge clk);
    end
    ui_in[0] = 1'b0;
    ui_in[1] = 1'b0;
    if (release_cs) begin
      repeat (4) @(negedge clk);
      ui_in[2] = 1'b1;
    end
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    spi_send({1'b1, addr, data}, 16, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n  = 1'b1;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h04;
    repeat (3) @(negedge clk);
    n_checks++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h want 00", uo_out); end
    n_checks++;
    if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h want 00", uio_out); end
    n_checks++;
    if (uio_oe !== 8'hFF) begin n_fail++; $display("FAIL reset_uio_oe: got %h want FF", uio_oe); end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (uio_oe !== 8'hFF) begin n_fail++; $display("FAIL post_reset_uio_oe: got %h want FF", uio_oe); end
    n_checks++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL post_reset_uo_out: got %h want 00", uo_out); end
  endtask

  task automatic test_write;
    spi_send(16'h80F0, 16, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL write_latency_early: got %h want 00", uo_out); end
    @(negedge clk);
    n_checks++;
    if (uo_out !== 8'hF0) begin n_fail++; $display("FAIL write_en_out_lo: got %h want F0", uo_out); end
    spi_send(16'h81CC, 16, 1'b1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (uio_out !== 8'hCC) begin n_fail++; $display("FAIL write_en_out_hi: got %h want CC", uio_out); end
    n_checks++;
    if (uo_out !== 8'hF0) begin n_fail++; $display("FAIL write_hi_keeps_lo: got %h want F0", uo_out); end
  endtask

  task automatic test_dropped;
    spi_send(16'h00FF, 16, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++;
    if (uo_out !== 8'hF0) begin n_fail++; $display("FAIL read_frame_ignored: got %h want F0", uo_out); end
    spi_send(16'hB0AA, 16, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++;
    if ({uio_out, uo_out} !== 16'hCCF0) begin
      n_fail++; $display("FAIL addr_30_ignored: got %h want CCF0", {uio_out, uo_out});
    end
    spi_send(16'h85AA, 16, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++;
    if ({uio_out, uo_out} !== 16'hCCF0) begin
      n_fail++; $display("FAIL addr_05_ignored: got %h want CCF0", {uio_out, uo_out});
    end
  endtask

  task automatic test_short_frame;
    spi_send(16'h8055, 8, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++;
    if ({uio_out, uo_out} !== 16'hCCF0) begin
      n_fail++; $display("FAIL short_frame_dropped: got %h want CCF0", {uio_out, uo_out});
    end
  endtask

  task automatic test_pwm;
    int  t;
    int  hi;
    int  lo;
    bit  prev;
    bit  found;
    spi_write(7'h02, 8'h01);
    spi_write(7'h04, 8'h80);
    spi_write(7'h00, 8'h01);
    n_checks++;
    if (uo_out[7:1] !== 7'h00) begin n_fail++; $display("FAIL pwm_other_bits: got %h want 00", uo_out[7:1]); end
    // Find a rising edge of output 0, then time one high and one low phase.
    found = 1'b0;
    prev  = uo_out[0];
    for (t = 0; t < 8000 && !found; t++) begin
      @(negedge clk);
      if (!prev && uo_out[0]) found = 1'b1;
      prev = uo_out[0];
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL pwm_rise_timeout: got no edge want rising edge"); end
    hi = 0;
    while (uo_out[0] === 1'b1 && hi < 8000) begin @(negedge clk); hi++; end
    lo = 0;
    while (uo_out[0] === 1'b0 && lo < 8000) begin @(negedge clk); lo++; end
    n_checks++;
    if (hi < 1663 || hi > 1665) begin n_fail++; $display("FAIL pwm_high_time: got %0d want 1664", hi); end
    n_checks++;
    if (hi + lo < 3327 || hi + lo > 3329) begin
      n_fail++; $display("FAIL pwm_period: got %0d want 3328", hi + lo);
    end

    spi_write(7'h04, 8'h00);
    hi = 0;
    for (int i = 0; i < 3400; i++) begin @(negedge clk); if (uo_out[0] !== 1'b0) hi++; end
    n_checks++;
    if (hi != 0) begin n_fail++; $display("FAIL pwm_duty_00: got %0d high cycles want 0", hi); end

    spi_write(7'h04, 8'hFF);
    lo = 0;
    for (int i = 0; i < 3400; i++) begin @(negedge clk); if (uo_out[0] !== 1'b1) lo++; end
    n_checks++;
    if (lo != 0) begin n_fail++; $display("FAIL pwm_duty_ff: got %0d low cycles want 0", lo); end
  endtask

  task automatic test_reset_midframe;
    spi_send(16'h8055, 10, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({uio_out, uo_out} !== 16'h0000) begin
      n_fail++; $display("FAIL midframe_reset_clears: got %h want 0000", {uio_out, uo_out});
    end
    ui_in[2] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (uo_out !== 8'h00) begin n_fail++; $display("FAIL partial_frame_discarded: got %h want 00", uo_out); end
    spi_write(7'h00, 8'h55);
    n_checks++;
    if (uo_out !== 8'h55) begin n_fail++; $display("FAIL write_after_reset: got %h want 55", uo_out); end
  endtask

  task automatic test_long_frame;
    logic [7:0] exp;
`ifdef SPI_LEN_CHECK_EN
    exp = 8'h55;
`else
    exp = 8'h33;
`endif
    spi_send(16'h8033, 17, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++;
    if (uo_out !== exp) begin n_fail++; $display("FAIL long_frame: got %h want %h", uo_out, exp); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_dropped();
    test_short_frame();
    test_pwm();
    test_reset_midframe();
    test_long_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
